// File: rtl/cps2_sync_conditioner.sv
// rtl/cps2_sync_conditioner.sv - CPS2 sync deglitch, data alignment, line/frame measurement and lock FSM
//
// cps2_sync_filter: per-sync deglitcher.
//   clk_i, reset_i  clock / synchronous active-high reset
//   raw_i           raw active-low sync sample
//   filt_o          filtered sync (resets to 1)
//
// cps2_sync_conditioner: sits between the PCLK2x input latches and cps2_frontend.
//   PCLK2x_i, reset                 clock / synchronous active-high reset
//   R_i, G_i, B_i, F_i              latched pixel nibbles
//   HSYNC_i, VSYNC_i                latched raw syncs, active low
//   R_o, G_o, B_o, F_o              nibbles delayed by SYNC_FILT_LEN clocks
//   HSYNC_o, VSYNC_o                filtered syncs, same delay as the nibbles
//   hperiod_o                       clocks between the last two HSYNC falling edges
//   vlines_o                        HSYNC falling edges in the last complete frame
//   frame_strobe_o                  1-cycle pulse when vlines_o updates
//   sync_valid_o                    high while the lock FSM is in LOCKED (1 clock late)

module cps2_sync_filter #(
    parameter int LEN = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    output logic filt_o
);
    localparam logic [3:0] LAST = 4'(LEN - 1);

    logic       filt_q;
    logic [3:0] cnt_q;

    // cnt_q counts consecutive samples disagreeing with the filtered level;
    // the level flips on the LEN-th such sample.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            filt_q <= 1'b1;
            cnt_q  <= '0;
        end else if (raw_i == filt_q) begin
            cnt_q <= '0;
        end else if (cnt_q == LAST) begin
            filt_q <= raw_i;
            cnt_q  <= '0;
        end else begin
            cnt_q <= cnt_q + 4'd1;
        end
    end

    assign filt_o = filt_q;
endmodule

module cps2_sync_conditioner #(
    parameter int SYNC_FILT_LEN = 4,
    parameter int HTOL          = 2,
    parameter int LOCK_LINES    = 16,
    parameter int HTIMEOUT      = 4000
) (
    input  logic        PCLK2x_i,
    input  logic        reset,
    input  logic [3:0]  R_i,
    input  logic [3:0]  G_i,
    input  logic [3:0]  B_i,
    input  logic [3:0]  F_i,
    input  logic        HSYNC_i,
    input  logic        VSYNC_i,
    output logic [3:0]  R_o,
    output logic [3:0]  G_o,
    output logic [3:0]  B_o,
    output logic [3:0]  F_o,
    output logic        HSYNC_o,
    output logic        VSYNC_o,
    output logic [11:0] hperiod_o,
    output logic [9:0]  vlines_o,
    output logic        frame_strobe_o,
    output logic        sync_valid_o
);
    localparam logic [11:0] HTOL_W    = 12'(HTOL);
    localparam logic [11:0] TMO_W     = 12'(HTIMEOUT);
    localparam logic [7:0]  LOCK_W    = 8'(LOCK_LINES);
    localparam logic [11:0] HCNT_MAX  = 12'hFFF;
    localparam logic [9:0]  LINE_MAX  = 10'h3FF;

    typedef enum logic [1:0] {ST_NOSYNC, ST_ACQUIRE, ST_LOCKED} state_t;

    state_t      state_q, state_d;
    logic [7:0]  match_q, match_d;
    logic [15:0] pipe_q [SYNC_FILT_LEN];
    logic        h_filt, v_filt, h_prev_q, v_prev_q;
    logic [11:0] h_cnt_q, hperiod_q, h_new, h_diff;
    logic [9:0]  line_cnt_q, vlines_q;
    logic        frame_seen_q, strobe_q, sync_valid_q;
    logic        h_edge, v_edge, timeout, h_take, in_tol;

    cps2_sync_filter #(.LEN(SYNC_FILT_LEN)) u_hfilt (
        .clk_i(PCLK2x_i), .reset_i(reset), .raw_i(HSYNC_i), .filt_o(h_filt)
    );
    cps2_sync_filter #(.LEN(SYNC_FILT_LEN)) u_vfilt (
        .clk_i(PCLK2x_i), .reset_i(reset), .raw_i(VSYNC_i), .filt_o(v_filt)
    );

    // Edge cycle = first cycle the filtered sync shows 0.
    assign h_edge  = h_prev_q & ~h_filt;
    assign v_edge  = v_prev_q & ~v_filt;
    assign timeout = (h_cnt_q == TMO_W);
    // A timeout swallows a coincident H edge entirely.
    assign h_take  = h_edge & ~timeout;
    assign h_new   = (h_cnt_q == HCNT_MAX) ? HCNT_MAX : h_cnt_q + 12'd1;
    assign h_diff  = (h_new >= hperiod_q) ? h_new - hperiod_q : hperiod_q - h_new;
    // hperiod 0 means no reference yet, so the first measured line is accepted.
    assign in_tol  = (hperiod_q == 12'd0) || (h_diff <= HTOL_W);

    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (timeout) begin
            state_d = ST_NOSYNC;
            match_d = '0;
        end else if (h_take) begin
            case (state_q)
                ST_NOSYNC: begin
                    state_d = ST_ACQUIRE;
                    match_d = '0;
                end
                ST_ACQUIRE: begin
                    if (in_tol) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 >= LOCK_W) state_d = ST_LOCKED;
                    end else begin
                        match_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!in_tol) begin
                        state_d = ST_ACQUIRE;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = ST_NOSYNC;
                    match_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge PCLK2x_i) begin
        if (reset) begin
            state_q      <= ST_NOSYNC;
            match_q      <= '0;
            for (int i = 0; i < SYNC_FILT_LEN; i++) pipe_q[i] <= '0;
            h_prev_q     <= 1'b1;
            v_prev_q     <= 1'b1;
            h_cnt_q      <= '0;
            hperiod_q    <= '0;
            line_cnt_q   <= '0;
            vlines_q     <= '0;
            frame_seen_q <= 1'b0;
            strobe_q     <= 1'b0;
            sync_valid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            pipe_q[0] <= {R_i, G_i, B_i, F_i};
            for (int i = 1; i < SYNC_FILT_LEN; i++) pipe_q[i] <= pipe_q[i-1];
            h_prev_q <= h_filt;
            v_prev_q <= v_filt;

            if (h_take)                  h_cnt_q <= '0;
            else if (h_cnt_q != HCNT_MAX) h_cnt_q <= h_cnt_q + 12'd1;

            if (timeout)                                hperiod_q <= '0;
            else if (h_take && state_q != ST_NOSYNC)    hperiod_q <= h_new;

            // The H edge coincident with a V edge opens the new frame.
            if (v_edge) begin
                vlines_q     <= frame_seen_q ? line_cnt_q : 10'd0;
                frame_seen_q <= 1'b1;
                line_cnt_q   <= {9'd0, h_take};
            end else if (h_take && line_cnt_q != LINE_MAX) begin
                line_cnt_q <= line_cnt_q + 10'd1;
            end

            strobe_q     <= v_edge;
            sync_valid_q <= (state_q == ST_LOCKED);
        end
    end

    assign {R_o, G_o, B_o, F_o} = pipe_q[SYNC_FILT_LEN-1];
    assign HSYNC_o        = h_filt;
    assign VSYNC_o        = v_filt;
    assign hperiod_o      = hperiod_q;
    assign vlines_o       = vlines_q;
    assign frame_strobe_o = strobe_q;
    assign sync_valid_o   = sync_valid_q;
endmodule

// File: tb/tb_cps2_sync_conditioner.sv
// tb/tb_cps2_sync_conditioner.sv - self-checking bench for cps2_sync_conditioner
module tb_cps2_sync_conditioner;
    localparam int LEN = 4, HTOL = 2, LOCK_LINES = 16, HTIMEOUT = 4000;

    logic clk, reset, HSYNC_i, VSYNC_i;
    logic [3:0] R_i, G_i, B_i, F_i, R_o, G_o, B_o, F_o;
    logic HSYNC_o, VSYNC_o, frame_strobe_o, sync_valid_o;
    logic [11:0] hperiod_o;
    logic [9:0]  vlines_o;

    cps2_sync_conditioner #(.SYNC_FILT_LEN(LEN), .HTOL(HTOL), .LOCK_LINES(LOCK_LINES),
                            .HTIMEOUT(HTIMEOUT)) dut (
        .PCLK2x_i(clk), .reset(reset), .R_i(R_i), .G_i(G_i), .B_i(B_i), .F_i(F_i),
        .HSYNC_i(HSYNC_i), .VSYNC_i(VSYNC_i), .R_o(R_o), .G_o(G_o), .B_o(B_o), .F_o(F_o),
        .HSYNC_o(HSYNC_o), .VSYNC_o(VSYNC_o), .hperiod_o(hperiod_o), .vlines_o(vlines_o),
        .frame_strobe_o(frame_strobe_o), .sync_valid_o(sync_valid_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0, failures = 0;
    bit chk_en = 0;
    int strobe_cnt = 0, exp_strobes = 0;
    logic [15:0] last_data;

    // Model state: filters as sample histories, line timing as cycle stamps.
    int cyc = 0, ref_step = 0, match = 0, m_hp = 0, m_vl = 0, m_lines = 0;
    logic [LEN-1:0] h_hist, v_hist;
    logic [15:0] d_hist [LEN];
    bit m_hf = 1, m_vf = 1, h_pend = 0, v_pend = 0, nosync = 1, locked = 0;
    bit vseen = 0, m_strobe = 0, m_sv = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int hc, newp, d;
        bit hedge, vedge, tmo, cnt, tol;
        cyc++;
        if (reset) begin
            h_hist = '1; v_hist = '1; m_hf = 1; m_vf = 1; h_pend = 0; v_pend = 0;
            for (int i = 0; i < LEN; i++) d_hist[i] = '0;
            ref_step = cyc; nosync = 1; locked = 0; match = 0;
            m_hp = 0; m_vl = 0; m_lines = 0; vseen = 0; m_strobe = 0; m_sv = 0;
            return;
        end
        hedge = h_pend;
        vedge = v_pend;
        hc = cyc - ref_step - 1;
        if (hc > 4095) hc = 4095;
        tmo = (hc == HTIMEOUT);
        cnt = hedge && !tmo;
        m_sv = locked;
        if (tmo) begin
            nosync = 1; locked = 0; match = 0; m_hp = 0;
        end else if (cnt) begin
            if (nosync) begin
                nosync = 0; match = 0;
            end else begin
                newp = (hc + 1 > 4095) ? 4095 : hc + 1;
                d = newp - m_hp;
                if (d < 0) d = -d;
                tol = (m_hp == 0) || (d <= HTOL);
                if (locked) begin
                    if (!tol) begin locked = 0; match = 0; end
                end else if (tol) begin
                    match++;
                    if (match >= LOCK_LINES) locked = 1;
                end else begin
                    match = 0;
                end
                m_hp = newp;
            end
            ref_step = cyc;
        end
        if (vedge) begin
            m_vl = vseen ? m_lines : 0;
            vseen = 1;
            m_lines = cnt ? 1 : 0;
        end else if (cnt && m_lines < 1023) begin
            m_lines++;
        end
        m_strobe = vedge;
        h_hist = {h_hist[LEN-2:0], HSYNC_i};
        v_hist = {v_hist[LEN-2:0], VSYNC_i};
        h_pend = 0; v_pend = 0;
        if (m_hf && h_hist == '0) begin m_hf = 0; h_pend = 1; end
        else if (!m_hf && h_hist == '1) m_hf = 1;
        if (m_vf && v_hist == '0) begin m_vf = 0; v_pend = 1; end
        else if (!m_vf && v_hist == '1) m_vf = 1;
        for (int i = LEN - 1; i > 0; i--) d_hist[i] = d_hist[i-1];
        d_hist[0] = {R_i, G_i, B_i, F_i};
    endtask

    always @(negedge clk) begin
        if (frame_strobe_o === 1'b1) strobe_cnt++;
        if (chk_en) begin
            chk("HSYNC_o", HSYNC_o, m_hf);
            chk("VSYNC_o", VSYNC_o, m_vf);
            chk("data_o", {R_o, G_o, B_o, F_o}, d_hist[LEN-1]);
            chk("hperiod_o", hperiod_o, m_hp);
            chk("vlines_o", vlines_o, m_vl);
            chk("frame_strobe_o", frame_strobe_o, m_strobe);
            chk("sync_valid_o", sync_valid_o, m_sv);
        end
    end

    task automatic step(input bit rst, input bit h, input bit v);
        @(negedge clk);
        reset = rst; HSYNC_i = h; VSYNC_i = v;
        last_data = 16'($urandom);
        {R_i, G_i, B_i, F_i} = last_data;
        @(posedge clk);
        model_step();
    endtask

    // H low for 5 clocks at line start; optional 6-clock V pulse from vstart.
    task automatic line(input int len, input int vstart);
        for (int s = 0; s < len; s++)
            step(1'b0, s >= 5, !(vstart >= 0 && s >= vstart && s < vstart + 6));
        if (vstart >= 0) exp_strobes++;
    endtask

    int lens [1:36];
    logic [15:0] d0;
    int expv [4] = '{0, 262, 261, 262};

    initial begin
        reset = 1; HSYNC_i = 1; VSYNC_i = 1; {R_i, G_i, B_i, F_i} = '0;
        // Reset with random raw inputs.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'($urandom), 1'($urandom));
            chk_en = 1;
        end
        #1;
        chk("rst_HSYNC_o", HSYNC_o, 1);
        chk("rst_VSYNC_o", VSYNC_o, 1);
        chk("rst_data_o", {R_o, G_o, B_o, F_o}, 0);
        chk("rst_sync_valid_o", sync_valid_o, 0);
        chk("rst_hperiod_o", hperiod_o, 0);
        chk("rst_vlines_o", vlines_o, 0);

        // Glitch rejection, then a clean 4-clock edge.
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 11; i++) begin
            step(1'b0, i >= 3, 1'b1);
            #1 chk("glitch_HSYNC_o", HSYNC_o, 1);
        end
        step(1'b0, 1'b0, 1'b1);
        d0 = last_data;
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        #1 chk("edge_early_HSYNC_o", HSYNC_o, 1);
        step(1'b0, 1'b0, 1'b1);
        #1;
        chk("edge_HSYNC_o", HSYNC_o, 0);
        chk("edge_data_o", {R_o, G_o, B_o, F_o}, d0);
        for (int i = 0; i < 6; i++) step(1'b0, i >= 2, 1'b1);

        // Lock with +/-1 jitter, one long line, relock.
        step(1'b1, 1'b1, 1'b1);
        for (int k = 1; k <= 36; k++) lens[k] = 1024 + (k % 3) - 1;
        lens[18] = 1030;
        for (int k = 1; k <= 36; k++) begin
            line(lens[k], -1);
            #1;
            if (k == 16 || k == 35) chk("pre_lock_sync_valid", sync_valid_o, 0);
            if (k == 17 || k == 36) chk("lock_sync_valid", sync_valid_o, 1);
            if (k == 17) chk("lock_hperiod", hperiod_o, lens[16]);
            if (k == 19) begin
                chk("unlock_sync_valid", sync_valid_o, 0);
                chk("unlock_hperiod", hperiod_o, 1030);
            end
        end

        // Timeout while locked, then resume.
        for (int i = 0; i < 2900; i++) step(1'b0, 1'b1, 1'b1);
        #1 chk("pre_tmo_sync_valid", sync_valid_o, 1);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b1, 1'b1);
        #1;
        chk("tmo_sync_valid", sync_valid_o, 0);
        chk("tmo_hperiod", hperiod_o, 0);
        line(1024, -1);
        #1 chk("resume1_hperiod", hperiod_o, 0);
        line(1024, -1);
        #1 chk("resume2_hperiod", hperiod_o, 1024);

        // Frames of 262 lines; frames 2 and 3 start with a coincident V/H edge.
        step(1'b1, 1'b1, 1'b1);
        for (int f = 0; f < 4; f++) begin
            for (int l = 0; l < 262; l++) begin
                line(20, (l == 0) ? ((f < 2) ? 8 : 0) : -1);
                if (l == 0) begin
                    #1;
                    chk("frame_vlines", vlines_o, expv[f]);
                    chk("frame_strobes", strobe_cnt, exp_strobes);
                    if (f == 3) break;
                end
            end
        end

        // Saturation, then a mid-frame reset.
        step(1'b1, 1'b1, 1'b1);
        line(14, 4);
        #1 chk("sat_first_vlines", vlines_o, 0);
        for (int l = 0; l < 1100; l++) line(14, -1);
        line(14, 4);
        #1 chk("sat_vlines", vlines_o, 1023);
        for (int l = 0; l < 30; l++) line(14, -1);
        step(1'b1, 1'b1, 1'b1);
        #1 chk("midrst_vlines", vlines_o, 0);
        for (int l = 0; l < 20; l++) line(14, -1);
        line(14, 4);
        #1 chk("post_rst_first_vlines", vlines_o, 0);
        for (int l = 0; l < 39; l++) line(14, -1);
        line(14, 4);
        #1;
        chk("post_rst_vlines", vlines_o, 40);
        chk("total_strobes", strobe_cnt, exp_strobes);

        chk_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
